// File: rtl/adder_tree_sched_pkg.sv
// Shared types and constants for the 64-input adder tree scheduler.
// Provides: mode/state enums, tree geometry constants, mode decode helpers.
package raven_tree_pkg;

    localparam int TREE_IN  = 64;
    localparam int L1_LANES = 16;
    localparam int L2_LANES = 4;
    localparam int TREE_LAT = 3;

    typedef enum logic [1:0] {
        L1 = 2'd0,
        L2 = 2'd1,
        L3 = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN,
        RESULT
    } state_e;

    // Encoding 3 has no tap of its own; it reduces fully like L3.
    function automatic mode_e to_mode(input logic [1:0] m);
        unique case (m)
            2'd0:    return L1;
            2'd1:    return L2;
            default: return L3;
        endcase
    endfunction

    // Valid-pipe stages that can still carry a beat headed for the tap.
    function automatic logic [TREE_LAT-1:0] lvl_mask(input mode_e m);
        unique case (m)
            L1:      return 3'b001;
            L2:      return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/adder_tree_sched_if.sv
// Handshake bundle for the scheduler: command, operand beat and result.
// master = PE side (drives cmd/in, consumes res); slave = scheduler.
interface adder_tree_sched_if #(
    parameter int ACC_BW  = 32,
    parameter int BEAT_BW = 16
);
    import raven_tree_pkg::*;

    logic                              cmd_valid;
    logic                              cmd_ready;
    logic [BEAT_BW-1:0]                cmd_beats;
    logic [1:0]                        cmd_mode;

    logic                              in_valid;
    logic                              in_ready;
    logic [TREE_IN-1:0][ACC_BW-1:0]    in_data;

    logic                              res_valid;
    logic                              res_ready;
    logic [L1_LANES-1:0][ACC_BW-1:0]   res_data;

    modport master (
        output cmd_valid, cmd_beats, cmd_mode,
        input  cmd_ready,
        output in_valid, in_data,
        input  in_ready,
        input  res_valid, res_data,
        output res_ready
    );

    modport slave (
        input  cmd_valid, cmd_beats, cmd_mode,
        output cmd_ready,
        input  in_valid, in_data,
        output in_ready,
        output res_valid, res_data,
        input  res_ready
    );

endinterface

// File: rtl/adder_tree_sched_sat_acc_lane.sv
// One unsigned saturating accumulator lane with synchronous clear.
// Ports: clk, rst_n, clr_i (clear, wins), en_i (add), tap_i, acc_o.
module sat_acc_lane #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] tap_i,
    output logic [W-1:0] acc_o
);

    logic [W-1:0] acc_q;
    logic [W-1:0] acc_d;
    logic [W:0]   sum;

    assign sum = {1'b0, acc_q} + {1'b0, tap_i};

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = sum[W] ? '1 : sum[W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/adder_tree_sched.sv
// Sequences multi-beat reductions through the 3-level pipelined adder tree.
// Ports: clk, rst_n, bus (cmd/in/res handshakes), tree_in, tree_l1..l3, busy.
module adder_tree_sched
    import raven_tree_pkg::*;
#(
    parameter int ACC_BW  = 32,
    parameter int BEAT_BW = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    adder_tree_sched_if.slave               bus,
    output logic [TREE_IN-1:0][ACC_BW-1:0]  tree_in,
    input  logic [L1_LANES-1:0][ACC_BW-1:0] tree_l1,
    input  logic [L2_LANES-1:0][ACC_BW-1:0] tree_l2,
    input  logic [ACC_BW-1:0]               tree_l3,
    output logic                            busy
);

    state_e                          state_q;
    mode_e                           mode_q;
    logic [BEAT_BW-1:0]              cnt_q;
    logic [TREE_LAT-1:0]             vld_q;
    logic [TREE_LAT-1:0]             vld_d;
    logic                            cmd_ready_q;
    logic                            in_ready_q;
    logic                            res_valid_q;
    logic                            busy_q;
    logic [L1_LANES-1:0][ACC_BW-1:0] res_data_q;

    logic [L1_LANES-1:0][ACC_BW-1:0] tap;
    logic [L1_LANES-1:0][ACC_BW-1:0] acc;
    logic                            cmd_fire;
    logic                            in_fire;
    logic                            res_fire;
    logic                            tap_vld;
    logic                            acc_en;
    logic                            last_beat;
    logic                            drained;

    assign cmd_fire  = bus.cmd_valid & cmd_ready_q;
    assign in_fire   = bus.in_valid & in_ready_q;
    assign res_fire  = res_valid_q & bus.res_ready;
    assign last_beat = (cnt_q == BEAT_BW'(1));

    // Non-firing slots feed zeros so the tree never carries stale data.
    assign tree_in = in_fire ? bus.in_data : '0;

    // vld_q[k] marks a real beat at tree level k+1 this cycle.
    assign vld_d = {vld_q[TREE_LAT-2:0], in_fire};

    // No beat remains between the tree input and the selected tap.
    assign drained = ((vld_q & lvl_mask(mode_q)) == '0);

    always_comb begin
        tap     = '0;
        tap_vld = 1'b0;
        unique case (1'b1)
            (mode_q == L1): begin
                tap     = tree_l1;
                tap_vld = vld_q[0];
            end
            (mode_q == L2): begin
                for (int j = 0; j < L2_LANES; j++) begin
                    tap[j] = tree_l2[j];
                end
                tap_vld = vld_q[1];
            end
            default: begin
                tap[0]  = tree_l3;
                tap_vld = vld_q[2];
            end
        endcase
    end

    assign acc_en = tap_vld & ((state_q == STREAM) | (state_q == DRAIN));

    for (genvar j = 0; j < L1_LANES; j++) begin : g_lane
        sat_acc_lane #(
            .W(ACC_BW)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .clr_i (cmd_fire),
            .en_i  (acc_en),
            .tap_i (tap[j]),
            .acc_o (acc[j])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mode_q      <= L1;
            cnt_q       <= '0;
            vld_q       <= '0;
            cmd_ready_q <= 1'b0;
            in_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            res_data_q  <= '0;
        end else begin
            vld_q <= vld_d;
            unique case (state_q)
                IDLE: begin
                    if (cmd_fire) begin
                        mode_q      <= to_mode(bus.cmd_mode);
                        cnt_q       <= bus.cmd_beats;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (bus.cmd_beats == '0) begin
                            state_q     <= RESULT;
                            res_valid_q <= 1'b1;
                            res_data_q  <= '0;
                        end else begin
                            state_q    <= STREAM;
                            in_ready_q <= 1'b1;
                        end
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                STREAM: begin
                    if (in_fire) begin
                        cnt_q <= cnt_q - BEAT_BW'(1);
                        if (last_beat) begin
                            state_q    <= DRAIN;
                            in_ready_q <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (drained) begin
                        state_q     <= RESULT;
                        res_valid_q <= 1'b1;
                        res_data_q  <= acc;
                    end
                end
                RESULT: begin
                    if (res_fire) begin
                        state_q     <= IDLE;
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_adder_tree_sched.sv
// Directed bench for adder_tree_sched with a behavioural 3-level tree.
// Each level sums 4 inputs and scales by 1/4, registered on clk.
module tb_adder_tree_sched;
    import raven_tree_pkg::*;

    localparam int W  = 32;
    localparam int BB = 16;

    typedef logic [TREE_IN-1:0][W-1:0]  beat_t;
    typedef logic [L1_LANES-1:0][W-1:0] res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    beat_t                      tree_in;
    res_t                       tree_l1;
    logic [L2_LANES-1:0][W-1:0] tree_l2;
    logic [W-1:0]               tree_l3;
    logic                       busy;

    int   checks = 0;
    int   failures = 0;
    logic saw_in_ready = 1'b0;
    logic saw_res_valid = 1'b0;

    adder_tree_sched_if #(.ACC_BW(W), .BEAT_BW(BB)) bus ();

    adder_tree_sched #(
        .ACC_BW  (W),
        .BEAT_BW (BB)
    ) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus.slave),
        .tree_in (tree_in),
        .tree_l1 (tree_l1),
        .tree_l2 (tree_l2),
        .tree_l3 (tree_l3),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] avg4(input logic [W-1:0] a, b, c, d);
        logic [W+1:0] s;
        s = {2'b0, a} + {2'b0, b} + {2'b0, c} + {2'b0, d};
        return s[W+1:2];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tree_l1 <= '0;
            tree_l2 <= '0;
            tree_l3 <= '0;
        end else begin
            for (int j = 0; j < L1_LANES; j++) begin
                tree_l1[j] <= avg4(tree_in[4*j], tree_in[4*j+1],
                                   tree_in[4*j+2], tree_in[4*j+3]);
            end
            for (int j = 0; j < L2_LANES; j++) begin
                tree_l2[j] <= avg4(tree_l1[4*j], tree_l1[4*j+1],
                                   tree_l1[4*j+2], tree_l1[4*j+3]);
            end
            tree_l3 <= avg4(tree_l2[0], tree_l2[1], tree_l2[2], tree_l2[3]);
        end
    end

    task automatic check(input string tag, input logic [511:0] obs,
                         input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.in_ready === 1'b1) saw_in_ready = 1'b1;
        if (bus.res_valid === 1'b1) saw_res_valid = 1'b1;
    endtask

    function automatic beat_t fill(input logic [W-1:0] v);
        beat_t b;
        for (int i = 0; i < TREE_IN; i++) b[i] = v;
        return b;
    endfunction

    function automatic beat_t ramp();
        beat_t b;
        for (int i = 0; i < TREE_IN; i++) b[i] = W'(i);
        return b;
    endfunction

    task automatic send_cmd(input int beats, input int mode);
        int n;
        n = 0;
        bus.cmd_beats = BB'(beats);
        bus.cmd_mode  = 2'(mode);
        bus.cmd_valid = 1'b1;
        while (bus.cmd_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("cmd_accept", 512'(bus.cmd_ready), 512'(1));
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic send_beat(input beat_t d);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("beat_accept", 512'(bus.in_ready), 512'(1));
        tick();
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
    endtask

    task automatic wait_res(output int edges);
        edges = 0;
        while (bus.res_valid !== 1'b1 && edges < 50) begin
            tick();
            edges++;
        end
    endtask

    task automatic take_res();
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
    endtask

    initial begin
        int   e;
        res_t exp_r;

        bus.cmd_valid = 1'b0;
        bus.cmd_beats = '0;
        bus.cmd_mode  = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.res_ready = 1'b0;

        // Reset state
        #12;
        check("rst_cmd_ready", 512'(bus.cmd_ready), 512'(0));
        check("rst_in_ready", 512'(bus.in_ready), 512'(0));
        check("rst_res_valid", 512'(bus.res_valid), 512'(0));
        check("rst_res_data", 512'(bus.res_data), 512'(0));
        check("rst_busy", 512'(busy), 512'(0));
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        tick();
        check("post_rst_cmd_ready", 512'(bus.cmd_ready), 512'(1));

        // L3, one beat of 64s: 4096 >> 6 = 64 on lane 0
        send_cmd(1, 2);
        check("t1_busy", 512'(busy), 512'(1));
        send_beat(fill(W'(64)));
        wait_res(e);
        check("t1_latency", 512'(e), 512'(4));
        exp_r = '0;
        exp_r[0] = W'(64);
        check("t1_data", 512'(bus.res_data), 512'(exp_r));
        check("t1_cmd_ready_res", 512'(bus.cmd_ready), 512'(0));
        take_res();
        check("t1_one_cycle_res", 512'(bus.res_valid), 512'(0));

        // L1, 3 ramp beats, 1-on/1-off with junk data in the bubbles
        send_cmd(3, 0);
        for (int b = 0; b < 3; b++) begin
            send_beat(ramp());
            if (b < 2) begin
                bus.in_data = fill('1);
                tick();
                bus.in_data = '0;
            end
        end
        wait_res(e);
        check("t2_latency", 512'(e), 512'(2));
        for (int j = 0; j < L1_LANES; j++) exp_r[j] = W'(12 * j + 3);
        check("t2_data", 512'(bus.res_data), 512'(exp_r));
        take_res();

        // L2, 2 beats of all-ones: lanes 0..3 saturate
        send_cmd(2, 1);
        send_beat(fill('1));
        send_beat(fill('1));
        wait_res(e);
        check("t3_latency", 512'(e), 512'(3));
        exp_r = '0;
        for (int j = 0; j < L2_LANES; j++) exp_r[j] = '1;
        check("t3_data", 512'(bus.res_data), 512'(exp_r));
        take_res();

        // Zero beats: immediate zero result, no beat accepted
        saw_in_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = fill(W'(7));
        send_cmd(0, 1);
        check("t4_res_valid", 512'(bus.res_valid), 512'(1));
        check("t4_data", 512'(bus.res_data), 512'(0));
        take_res();
        tick();
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        check("t4_no_in_ready", 512'(saw_in_ready), 512'(0));

        // Result back-pressure for 10 cycles
        send_cmd(1, 1);
        send_beat(fill(W'(4)));
        wait_res(e);
        check("t5_latency", 512'(e), 512'(3));
        exp_r = '0;
        for (int j = 0; j < L2_LANES; j++) exp_r[j] = W'(4);
        for (int c = 0; c < 10; c++) begin
            check("t5_hold_data", 512'(bus.res_data), 512'(exp_r));
            check("t5_hold_valid", 512'(bus.res_valid), 512'(1));
            check("t5_hold_cmd_ready", 512'(bus.cmd_ready), 512'(0));
            tick();
        end
        take_res();
        tick();
        check("t5_cmd_ready_after", 512'(bus.cmd_ready), 512'(1));

        // Reset during DRAIN aborts the command
        send_cmd(1, 2);
        send_beat(fill(W'(64)));
        tick();
        check("t6_busy_drain", 512'(busy), 512'(1));
        rst_n = 1'b0;
        #1;
        check("t6_cmd_ready", 512'(bus.cmd_ready), 512'(0));
        check("t6_in_ready", 512'(bus.in_ready), 512'(0));
        check("t6_res_valid", 512'(bus.res_valid), 512'(0));
        check("t6_res_data", 512'(bus.res_data), 512'(0));
        check("t6_busy", 512'(busy), 512'(0));
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        saw_res_valid = 1'b0;
        for (int c = 0; c < 8; c++) tick();
        check("t6_no_result", 512'(saw_res_valid), 512'(0));
        send_cmd(1, 2);
        send_beat(fill(W'(64)));
        wait_res(e);
        check("t6_latency", 512'(e), 512'(4));
        exp_r = '0;
        exp_r[0] = W'(64);
        check("t6_data", 512'(bus.res_data), 512'(exp_r));
        take_res();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
